// File: rtl/serial_to_parallel_lane.sv
// serial_to_parallel_lane
// Per-lane receive deserializer. Shifts one bit per clk2M cycle (MSB first),
// hunts for the COM symbol, locks byte alignment after LOCK_COUNT consecutive
// boundary-aligned COMs, then presents each received byte in parallel.
// Optional feature macro: S2P_ERR_CNT_EN adds a saturating misaligned-COM counter.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_RESET   | held in reset; first edge with reset_L high moves to SEARCH
// ST_SEARCH  | hunting for COM, counting consecutive boundary-aligned COMs
// ST_ALIGNED | locked; every 8th bit is presented on parallel_out
module serial_to_parallel_lane #(
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk2M,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] parallel_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
`ifdef S2P_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_ALIGNED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  // Only seven history bits are kept: the oldest bit of the 8-bit window is
  // shifted out in the same cycle it would be read.
  logic [6:0]  sr_q;
  logic [7:0]  sr_next;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  com_cnt_q, com_cnt_d, com_inc;
  logic [7:0]  pout_d;
  logic        valid_d, strobe_d, active_d;
  logic        is_com, boundary;
`ifdef S2P_ERR_CNT_EN
  logic [7:0]  err_d;
`endif

  // Next-state and next-output decode; everything is judged on sr_next.
  always_comb begin
    sr_next   = {sr_q, data_in};
    is_com    = (sr_next == COM);
    boundary  = (bit_cnt_q == 3'd7);
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    com_inc   = 4'd1;
    pout_d    = parallel_out;
    valid_d   = valid_out;
    strobe_d  = 1'b0;
    active_d  = active;
`ifdef S2P_ERR_CNT_EN
    err_d     = err_count;
`endif
    case (state_q)
      ST_RESET: begin
        state_d   = ST_SEARCH;
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
        pout_d    = 8'h00;
        valid_d   = 1'b0;
        active_d  = 1'b0;
      end
      ST_SEARCH: begin
        pout_d   = 8'h00;
        valid_d  = 1'b0;
        active_d = 1'b0;
        if (is_com) begin
          bit_cnt_d = 3'd0;
          // A COM off the boundary, or after a broken run, restarts the count at 1.
          if (boundary && (com_cnt_q >= 4'd1)) com_inc = com_cnt_q + 4'd1;
          else                                 com_inc = 4'd1;
          com_cnt_d = com_inc;
          if (com_inc == LOCK_CNT) begin
            state_d  = ST_ALIGNED;
            active_d = 1'b1;
          end
        end else if (boundary) begin
          com_cnt_d = 4'd0;
        end
      end
      ST_ALIGNED: begin
        if (boundary) begin
          pout_d   = sr_next;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
        end else if (is_com) begin
          // Misaligned COM: drop lock and treat it as the first COM of a new run.
          state_d   = ST_SEARCH;
          com_cnt_d = 4'd1;
          bit_cnt_d = 3'd0;
          pout_d    = 8'h00;
          valid_d   = 1'b0;
          active_d  = 1'b0;
`ifdef S2P_ERR_CNT_EN
          if (err_count != 8'hFF) err_d = err_count + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State, shift register, counters and registered outputs; reset wins over all.
  always_ff @(posedge clk2M) begin
    if (!reset_L) begin
      state_q      <= ST_RESET;
      sr_q         <= 7'd0;
      bit_cnt_q    <= 3'd0;
      com_cnt_q    <= 4'd0;
      parallel_out <= 8'h00;
      valid_out    <= 1'b0;
      byte_strobe  <= 1'b0;
      active       <= 1'b0;
`ifdef S2P_ERR_CNT_EN
      err_count    <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_next[6:0];
      bit_cnt_q    <= bit_cnt_d;
      com_cnt_q    <= com_cnt_d;
      parallel_out <= pout_d;
      valid_out    <= valid_d;
      byte_strobe  <= strobe_d;
      active       <= active_d;
`ifdef S2P_ERR_CNT_EN
      err_count    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_lane.sv
// Directed testbench for serial_to_parallel_lane (LOCK_COUNT = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_serial_to_parallel_lane;

  logic       clk2M = 1'b0;
  logic       reset_L;
  logic       data_in;
  logic [7:0] parallel_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
`ifdef S2P_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #10 clk2M = ~clk2M;

  serial_to_parallel_lane #(.LOCK_COUNT(4)) dut (
    .clk2M        (clk2M),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .parallel_out (parallel_out),
    .valid_out    (valid_out),
    .byte_strobe  (byte_strobe),
    .active       (active)
`ifdef S2P_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk2M);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int strobes);
    strobes = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (byte_strobe === 1'b1) strobes++;
    end
  endtask

  task automatic test_reset;
    logic [7:0] com;
    int s, nstb;
    com = 8'hBC;
    reset_L = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk2M);
      #1;
      checks++;
      if ({parallel_out, valid_out, byte_strobe, active} !== 11'h000) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h exp=000", i, {parallel_out, valid_out, byte_strobe, active});
      end
    end
`ifdef S2P_ERR_CNT_EN
    checks++;
    if (err_count !== 8'h00) begin failures++; $display("FAIL reset_err_count got=%h exp=00", err_count); end
`endif
    reset_L = 1'b1;
    nstb = 0;
    for (int k = 0; k < 3; k++) begin send_byte(com, s); nstb += s; end
    for (int i = 7; i >= 1; i--) begin send_bit(com[i]); if (byte_strobe === 1'b1) nstb++; end
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL prelock_bit31 active got=%b exp=0", active); end
    send_bit(com[0]);
    checks++;
    if (active !== 1'b1) begin failures++; $display("FAIL lock_bit32 active got=%b exp=1", active); end
    checks++;
    if ({parallel_out, valid_out, byte_strobe} !== 10'h000) begin
      failures++;
      $display("FAIL lock_edge_outputs got=%h exp=000", {parallel_out, valid_out, byte_strobe});
    end
    checks++;
    if (nstb != 0) begin failures++; $display("FAIL com_no_strobe got=%0d exp=0", nstb); end
  endtask

  task automatic test_data;
    logic [7:0] b;
    int s, changed;
    send_byte(8'hA5, s);
    checks++;
    if (s != 1 || byte_strobe !== 1'b1) begin
      failures++; $display("FAIL a5_strobe got_count=%0d got_now=%b exp=1/1", s, byte_strobe);
    end
    checks++;
    if (parallel_out !== 8'hA5 || valid_out !== 1'b1) begin
      failures++; $display("FAIL a5_data got=%h/%b exp=a5/1", parallel_out, valid_out);
    end
    b = 8'h3C;
    changed = 0;
    s = 0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      if (parallel_out !== 8'hA5) changed++;
      if (byte_strobe === 1'b1) s++;
    end
    checks++;
    if (changed != 0 || s != 0) begin
      failures++; $display("FAIL a5_hold changes=%0d strobes=%0d exp=0/0", changed, s);
    end
    send_bit(b[0]);
    checks++;
    if (parallel_out !== 8'h3C || byte_strobe !== 1'b1 || valid_out !== 1'b1) begin
      failures++; $display("FAIL 3c_data got=%h/%b/%b exp=3c/1/1", parallel_out, byte_strobe, valid_out);
    end
  endtask

  task automatic test_misaligned;
    int s, nstb;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    checks++;
    if (parallel_out !== 8'h0B || byte_strobe !== 1'b1) begin
      failures++; $display("FAIL slipped_byte got=%h/%b exp=0b/1", parallel_out, byte_strobe);
    end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    checks++;
    if ({parallel_out, valid_out, byte_strobe, active} !== 11'h000) begin
      failures++; $display("FAIL misaligned_drop got=%h exp=000", {parallel_out, valid_out, byte_strobe, active});
    end
`ifdef S2P_ERR_CNT_EN
    checks++;
    if (err_count !== 8'h01) begin failures++; $display("FAIL err_count got=%h exp=01", err_count); end
`endif
    nstb = 0;
    send_byte(8'hBC, s); nstb += s;
    send_byte(8'hBC, s); nstb += s;
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL relock_early active got=%b exp=0", active); end
    send_byte(8'hBC, s); nstb += s;
    checks++;
    if (active !== 1'b1 || nstb != 0) begin
      failures++; $display("FAIL relock active=%b strobes=%0d exp=1/0", active, nstb);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] com;
    int s;
    com = 8'hBC;
    send_byte(8'hA5, s);
    checks++;
    if (parallel_out !== 8'hA5 || valid_out !== 1'b1) begin
      failures++; $display("FAIL premid_data got=%h/%b exp=a5/1", parallel_out, valid_out);
    end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    reset_L = 1'b0;
    send_bit(1'b1);
    checks++;
    if ({parallel_out, valid_out, byte_strobe, active} !== 11'h000) begin
      failures++; $display("FAIL midbyte_reset got=%h exp=000", {parallel_out, valid_out, byte_strobe, active});
    end
`ifdef S2P_ERR_CNT_EN
    checks++;
    if (err_count !== 8'h00) begin failures++; $display("FAIL midbyte_err_count got=%h exp=00", err_count); end
`endif
    reset_L = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(com, s);
    for (int i = 7; i >= 1; i--) send_bit(com[i]);
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL restart_bit31 active got=%b exp=0", active); end
    send_bit(com[0]);
    checks++;
    if (active !== 1'b1) begin failures++; $display("FAIL restart_bit32 active got=%b exp=1", active); end
  endtask

  task automatic test_bit_slip;
    logic [7:0] com;
    int s;
    com = 8'hBC;
    reset_L = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    for (int k = 0; k < 3; k++) send_byte(com, s);
    for (int i = 7; i >= 1; i--) send_bit(com[i]);
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL slip_bit34 active got=%b exp=0", active); end
    send_bit(com[0]);
    checks++;
    if (active !== 1'b1) begin failures++; $display("FAIL slip_bit35 active got=%b exp=1", active); end
    send_byte(8'h3C, s);
    checks++;
    if (parallel_out !== 8'h3C || valid_out !== 1'b1 || s != 1) begin
      failures++; $display("FAIL slip_data got=%h/%b/%0d exp=3c/1/1", parallel_out, valid_out, s);
    end
  endtask

  task automatic test_broken_preamble;
    int s;
    reset_L = 1'b0;
    send_bit(1'b0);
    reset_L = 1'b1;
    send_byte(8'hBC, s);
    send_byte(8'hBC, s);
    send_byte(8'h00, s);
    send_byte(8'hBC, s);
    send_byte(8'hBC, s);
    send_byte(8'hBC, s);
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL broken_early active got=%b exp=0", active); end
    send_byte(8'hBC, s);
    checks++;
    if (active !== 1'b1) begin failures++; $display("FAIL broken_lock active got=%b exp=1", active); end
  endtask

  initial begin
    reset_L = 1'b0;
    data_in = 1'b0;
    @(posedge clk2M);
    #1;
    test_reset();
    test_data();
    test_misaligned();
    test_reset_mid();
    test_bit_slip();
    test_broken_preamble();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
